// File: rtl/float_pkg.sv
// +--------------------------------------------------------------------+
// | float_pkg : shared binary32 field widths, constants, FSM state type |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package float_pkg;

  localparam int FP_EXP_W   = 8;
  localparam int FP_FRAC_W  = 23;
  localparam int FP_BIAS    = 127;
  localparam int FP_EXP_MAX = 255;

  localparam logic [31:0] INT_INDEFINITE = 32'h8000_0000;
  localparam logic [31:0] INT_MAX_POS    = 32'h7FFF_FFFF;
  // -2^31 as binary32: the single e==31 value that still fits in int32
  localparam logic [31:0] F32_NEG_2P31   = 32'hCF00_0000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    NEGATE = 2'd2,
    DONE   = 2'd3
  } f2i_state_t;

endpackage

`default_nettype wire

// File: rtl/float_unpack.sv
// +--------------------------------------------------------------------+
// | float_unpack : combinational binary32 field split and classify     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module float_unpack
  import float_pkg::*;
(
  input  logic [31:0]              data_i,
  output logic                     sign_o,
  output logic signed [FP_EXP_W:0] exp_o,
  output logic [FP_FRAC_W:0]       mant_o,
  output logic                     is_nan_o,
  output logic                     is_inf_o,
  output logic                     is_zero_o,
  output logic                     is_denorm_o
);

  logic [FP_EXP_W-1:0]  exp_field;
  logic [FP_FRAC_W-1:0] frac_field;
  logic                 exp_all_ones;
  logic                 exp_all_zero;
  logic                 frac_zero;

  assign sign_o     = data_i[31];
  assign exp_field  = data_i[30:23];
  assign frac_field = data_i[22:0];

  assign exp_all_ones = (exp_field == FP_EXP_W'(FP_EXP_MAX));
  assign exp_all_zero = (exp_field == '0);
  assign frac_zero    = (frac_field == '0);

  assign exp_o  = $signed({1'b0, exp_field}) - $signed((FP_EXP_W+1)'(FP_BIAS));
  // Hidden bit is only present for normal numbers
  assign mant_o = {~exp_all_zero, frac_field};

  assign is_nan_o    = exp_all_ones & ~frac_zero;
  assign is_inf_o    = exp_all_ones &  frac_zero;
  assign is_zero_o   = exp_all_zero &  frac_zero;
  assign is_denorm_o = exp_all_zero & ~frac_zero;

endmodule

`default_nettype wire

// File: rtl/float_to_int.sv
// +--------------------------------------------------------------------+
// | float_to_int : iterative binary32 -> int32, round toward zero      |
// | Optional macro FLOAT_TO_INT_SATURATE_EN selects saturating results |
// | for invalid inputs. STEP (1,2,4,8) = bits shifted per SHIFT cycle. |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module float_to_int
  import float_pkg::*;
#(
  parameter int STEP = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out_data,
  output logic        out_invalid,
  output logic        out_inexact,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam logic [4:0] STEP_AMT = 5'(STEP);

  f2i_state_t  state_q;
  logic [31:0] mag_q;
  logic [31:0] mag_d;
  logic [4:0]  count_q;
  logic [4:0]  count_d;
  logic [4:0]  shift_amt;
  logic [31:0] lost_mask;
  logic        left_q;
  logic        sticky_q;
  logic        sticky_d;
  logic        sign_q;
  logic        invalid_q;

  logic [31:0] out_data_q;
  logic        out_valid_q;
  logic        out_invalid_q;
  logic        out_inexact_q;

  logic                     op_sign;
  logic signed [FP_EXP_W:0] op_exp;
  logic [FP_FRAC_W:0]       op_mant;
  logic                     op_nan;
  logic                     op_inf;
  logic                     op_zero;
  logic                     op_denorm;

  logic        op_special;
  logic        op_min_int;
  logic        op_ovf;
  logic        op_invalid;
  logic        op_small;
  logic [31:0] invalid_mag;

  logic [31:0] acc_mag_d;
  logic [4:0]  acc_count_d;
  logic        acc_left_d;
  logic        acc_sticky_d;
  logic        acc_sign_d;

  float_unpack u_unpack (
    .data_i      (in_data),
    .sign_o      (op_sign),
    .exp_o       (op_exp),
    .mant_o      (op_mant),
    .is_nan_o    (op_nan),
    .is_inf_o    (op_inf),
    .is_zero_o   (op_zero),
    .is_denorm_o (op_denorm)
  );

  assign op_special = op_nan | op_inf;
  assign op_min_int = (in_data == F32_NEG_2P31);
  assign op_ovf     = ~op_special && (op_exp >= 9'sd31) && ~op_min_int;
  assign op_invalid = op_special | op_ovf;
  assign op_small   = op_zero | op_denorm | (op_exp < 9'sd0);

`ifdef FLOAT_TO_INT_SATURATE_EN
  assign invalid_mag = op_nan  ? 32'd0 :
                       op_sign ? INT_INDEFINITE : INT_MAX_POS;
`else
  assign invalid_mag = INT_INDEFINITE;
`endif

  // Invalid results ride the normal datapath: the final value is loaded as
  // a positive magnitude with zero shift so NEGATE passes it through.
  always_comb begin
    acc_mag_d    = {{(32-FP_FRAC_W-1){1'b0}}, op_mant};
    acc_count_d  = 5'd0;
    acc_left_d   = 1'b0;
    acc_sticky_d = 1'b0;
    acc_sign_d   = op_sign;
    if (op_invalid) begin
      acc_mag_d  = invalid_mag;
      acc_sign_d = 1'b0;
    end else if (op_small) begin
      acc_mag_d    = '0;
      acc_sticky_d = ~op_zero;
    end else if (op_exp > 9'sd23) begin
      acc_count_d = op_exp[4:0] - 5'd23;
      acc_left_d  = 1'b1;
    end else begin
      acc_count_d = 5'd23 - op_exp[4:0];
    end
  end

  always_comb begin
    shift_amt = (count_q < STEP_AMT) ? count_q : STEP_AMT;
    lost_mask = ~(32'hFFFF_FFFF << shift_amt);
    count_d   = count_q - shift_amt;
    if (left_q) begin
      mag_d    = mag_q << shift_amt;
      sticky_d = sticky_q;
    end else begin
      mag_d    = mag_q >> shift_amt;
      sticky_d = sticky_q | (|(mag_q & lost_mask));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      mag_q         <= '0;
      count_q       <= '0;
      left_q        <= 1'b0;
      sticky_q      <= 1'b0;
      sign_q        <= 1'b0;
      invalid_q     <= 1'b0;
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
      out_invalid_q <= 1'b0;
      out_inexact_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            mag_q     <= acc_mag_d;
            count_q   <= acc_count_d;
            left_q    <= acc_left_d;
            sticky_q  <= acc_sticky_d;
            sign_q    <= acc_sign_d;
            invalid_q <= op_invalid;
            state_q   <= SHIFT;
          end
        end
        SHIFT: begin
          if (count_q == 5'd0) begin
            state_q <= NEGATE;
          end else begin
            mag_q    <= mag_d;
            count_q  <= count_d;
            sticky_q <= sticky_d;
          end
        end
        NEGATE: begin
          out_data_q    <= sign_q ? (~mag_q + 32'd1) : mag_q;
          out_invalid_q <= invalid_q;
          out_inexact_q <= sticky_q;
          out_valid_q   <= 1'b1;
          state_q       <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign out_invalid = out_invalid_q;
  assign out_inexact = out_inexact_q;

endmodule

`default_nettype wire

// File: tb/tb_float_to_int.sv
// +--------------------------------------------------------------------+
// | tb_float_to_int : scoreboard bench, two lanes (STEP=1 and STEP=8)  |
// | Honours FLOAT_TO_INT_SATURATE_EN in its reference model.           |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_float_to_int;

  typedef struct {
    logic [31:0] d;
    logic        inv;
    logic        inx;
    int          lat;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_total    = 0;
  int n_pass     = 0;
  int lanes_done = 0;

  logic [31:0] dir_vec [0:15] = '{
    32'h3F80_0000, 32'hC2F6_E666, 32'h4F00_0000, 32'hCF00_0000,
    32'h7FC0_0000, 32'hFF80_0000, 32'h0000_0001, 32'h8000_0000,
    32'h7F80_0000, 32'h4EFF_FFFF, 32'hCF00_0001, 32'hBF7F_FFFF,
    32'h4B00_0001, 32'h3F00_0000, 32'hC120_0000, 32'h4B7F_FFFF
  };

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_total++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, want);
  endtask

  // Value-level model: build the real number, then apply C-cast rules
  function automatic exp_t model(input logic [31:0] f, input int step);
    exp_t r;
    int   ebits;
    int   frac;
    int   t;
    int   cnt;
    real  mag;
    real  v;
    ebits = int'(f[30:23]);
    frac  = int'(f[22:0]);
    r.d = 32'd0; r.inv = 1'b0; r.inx = 1'b0; r.acc = 0; cnt = 0;
    if (ebits == 0) mag = $itor(frac) * $pow(2.0, -149.0);
    else            mag = ($itor(frac) + 8388608.0) * $pow(2.0, $itor(ebits - 150));
    v = f[31] ? -mag : mag;
    if (ebits == 255 || v >= 2147483648.0 || v < -2147483648.0) begin
      r.inv = 1'b1;
`ifdef FLOAT_TO_INT_SATURATE_EN
      if (ebits == 255 && frac != 0) r.d = 32'h0000_0000;
      else                           r.d = f[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`else
      r.d = 32'h8000_0000;
`endif
    end else begin
      t     = $rtoi(v);
      r.d   = t;
      r.inx = ($itor(t) != v);
      if (mag >= 1.0) cnt = (ebits >= 150) ? (ebits - 150) : (150 - ebits);
    end
    r.lat = (cnt + step - 1) / step + 2;
    return r;
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] r;
    int          k;
    r = $urandom;
    k = $urandom_range(0, 9);
    if (k <= 5)      r[30:23] = 8'($urandom_range(100, 160));
    else if (k == 6) r[30:23] = 8'hFF;
    else if (k == 7) r[30:23] = 8'h00;
    else if (k == 8) r[30:23] = 8'($urandom_range(156, 159));
    return r;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_lane
    localparam int LSTEP = (g == 0) ? 1 : 8;

    logic        rst       = 1'b1;
    logic [31:0] in_data   = 32'd0;
    logic        in_valid  = 1'b0;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_invalid;
    logic        out_inexact;
    logic        out_valid;
    logic        out_ready = 1'b1;
    int          cyc       = 0;
    int          bp_mode   = 0;
    exp_t        sb[$];

    float_to_int #(.STEP(LSTEP)) u_dut (
      .clk         (clk),
      .rst         (rst),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .out_data    (out_data),
      .out_invalid (out_invalid),
      .out_inexact (out_inexact),
      .out_valid   (out_valid),
      .out_ready   (out_ready)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Consumer back-pressure: 0 = always ready, 1 = random, 2 = stalled
    initial forever begin
      @(posedge clk);
      #1;
      case (bp_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end

    // Monitor: pops the scoreboard whenever a result is handed over
    initial begin
      logic pv;
      int   rise;
      exp_t e;
      pv   = 1'b0;
      rise = 0;
      forever begin
        @(negedge clk);
        if (rst) begin
          pv = 1'b0;
          continue;
        end
        if (out_valid && !pv) rise = cyc;
        pv = out_valid;
        if (out_valid && out_ready) begin
          n_total++;
          if (sb.size() == 0) begin
            $display("FAIL lane%0d unexpected_output: got data 0x%08h with empty scoreboard, want no output", g, out_data);
          end else begin
            n_pass++;
            e = sb.pop_front();
            chk($sformatf("lane%0d data", g),    out_data,            e.d);
            chk($sformatf("lane%0d invalid", g), {31'd0, out_invalid}, {31'd0, e.inv});
            chk($sformatf("lane%0d inexact", g), {31'd0, out_inexact}, {31'd0, e.inx});
            chk($sformatf("lane%0d latency", g), 32'(rise - e.acc),    32'(e.lat));
          end
          pv = 1'b0;
        end
      end
    end

    task automatic send(input logic [31:0] v, input bit track);
      int   waited;
      exp_t e;
      waited   = 0;
      in_data  = v;
      in_valid = 1'b1;
      while (!in_ready && waited < 300) begin
        @(negedge clk);
        waited++;
      end
      if (!in_ready) begin
        n_total++;
        $display("FAIL lane%0d accept_timeout: in_ready=0 after %0d cycles, want 1", g, waited);
      end else if (track) begin
        e     = model(v, LSTEP);
        e.acc = cyc + 1;
        sb.push_back(e);
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = $urandom;
    endtask

    task automatic drain();
      int w;
      w = 0;
      while (sb.size() != 0 && w < 2000) begin
        @(negedge clk);
        w++;
      end
      n_total++;
      if (sb.size() == 0) n_pass++;
      else $display("FAIL lane%0d drain: %0d results outstanding, want 0", g, sb.size());
    endtask

    initial begin
      exp_t e;
      int   w;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk($sformatf("lane%0d rst out_valid", g),   {31'd0, out_valid},   32'd0);
      chk($sformatf("lane%0d rst out_data", g),    out_data,             32'd0);
      chk($sformatf("lane%0d rst out_invalid", g), {31'd0, out_invalid}, 32'd0);
      chk($sformatf("lane%0d rst out_inexact", g), {31'd0, out_inexact}, 32'd0);
      chk($sformatf("lane%0d rst in_ready", g),    {31'd0, in_ready},    32'd1);

      foreach (dir_vec[i]) send(dir_vec[i], 1'b1);
      drain();

      // Held result must stay put while the consumer stalls
      bp_mode = 2;
      repeat (2) @(negedge clk);
      e = model(32'hC2F6_E666, LSTEP);
      send(32'hC2F6_E666, 1'b1);
      w = 0;
      while (!out_valid && w < 100) begin
        @(negedge clk);
        w++;
      end
      repeat (5) begin
        @(negedge clk);
        chk($sformatf("lane%0d stall out_valid", g),   {31'd0, out_valid},   32'd1);
        chk($sformatf("lane%0d stall out_data", g),    out_data,             e.d);
        chk($sformatf("lane%0d stall out_inexact", g), {31'd0, out_inexact}, {31'd0, e.inx});
        chk($sformatf("lane%0d stall in_ready", g),    {31'd0, in_ready},    32'd0);
      end
      bp_mode = 0;
      drain();

      // Reset during SHIFT discards the operand
      send(32'h3F80_0000, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk($sformatf("lane%0d midrst out_valid", g), {31'd0, out_valid}, 32'd0);
      chk($sformatf("lane%0d midrst in_ready", g),  {31'd0, in_ready},  32'd1);
      chk($sformatf("lane%0d midrst out_data", g),  out_data,           32'd0);
      repeat (30) @(negedge clk);
      send(32'h4B00_0001, 1'b1);
      drain();

      bp_mode = 1;
      repeat (60) begin
        send(rand_op(), 1'b1);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      drain();
      bp_mode = 0;
      lanes_done++;
    end
  end

  initial begin
    while (lanes_done < 2) @(negedge clk);
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: lanes_done=%0d, want 2", lanes_done);
    $fatal(1, "simulation time limit reached");
  end

endmodule

`default_nettype wire
